// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 receive path.
package hub75_pkg;

    localparam int COLS_DEF = 32;

    // Bit positions inside a pixel, matching the order of the panel data pins.
    localparam int R0 = 5;
    localparam int G0 = 4;
    localparam int B0 = 3;
    localparam int R1 = 2;
    localparam int G1 = 1;
    localparam int B1 = 0;

    typedef logic [5:0] pixel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/hub75_in_sync.sv
// Multi-stage synchronizer for one asynchronous level, with a one-cycle rising-edge pulse.
module hub75_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_panel_capture.sv
// HUB75 panel emulator: rebuilds shifted rows from the panel bus and streams each
// committed row to a framebuffer write port, with length/overrun/OE monitoring.
module hub75_panel_capture
    import hub75_pkg::*;
#(
    parameter int COLS        = COLS_DEF,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int OE_CNT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hub_clk,
    input  logic                            hub_lat,
    input  logic                            hub_oe,
    input  logic [ADDR_W-1:0]               hub_addr,
    input  logic [5:0]                      hub_rgb,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_W+$clog2(COLS)-1:0]  wr_addr,
    output logic [5:0]                      wr_data,
    output logic                            row_done,
    output logic                            frame_start,
    output logic                            len_err,
    output logic                            overrun,
    output logic [OE_CNT_W-1:0]             oe_cycles
);

    localparam int COL_W = $clog2(COLS);
    localparam int PIX_W = $clog2(COLS + 2);
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(COLS);
    localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(COLS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic clk_rise;
    logic lat_rise;

    hub75_in_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (hub_clk),
        .rise (clk_rise)
    );

    hub75_in_sync #(.STAGES(SYNC_STAGES)) u_lat_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (hub_lat),
        .rise (lat_rise)
    );

    // Data, address and OE are delayed by the same depth so they line up with the edges.
    pixel_t                 rgb_pipe_q  [SYNC_STAGES];
    pixel_t                 rgb_pipe_d  [SYNC_STAGES];
    logic [ADDR_W-1:0]      addr_pipe_q [SYNC_STAGES];
    logic [ADDR_W-1:0]      addr_pipe_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] oe_pipe_q;
    logic [SYNC_STAGES-1:0] oe_pipe_d;

    always_comb begin
        rgb_pipe_d[0]  = hub_rgb;
        addr_pipe_d[0] = hub_addr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rgb_pipe_d[i]  = rgb_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        oe_pipe_d = {oe_pipe_q[SYNC_STAGES-2:0], hub_oe};
    end

    // OE pipe resets to the inactive (high) level so reset does not count as on-time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_pipe_q  <= '{default: '0};
            addr_pipe_q <= '{default: '0};
            oe_pipe_q   <= '1;
        end else begin
            rgb_pipe_q  <= rgb_pipe_d;
            addr_pipe_q <= addr_pipe_d;
            oe_pipe_q   <= oe_pipe_d;
        end
    end

    pixel_t            rgb_s;
    logic [ADDR_W-1:0] addr_s;
    logic              oe_s;

    assign rgb_s  = rgb_pipe_q[SYNC_STAGES-1];
    assign addr_s = addr_pipe_q[SYNC_STAGES-1];
    assign oe_s   = oe_pipe_q[SYNC_STAGES-1];

    pixel_t              shift_q [COLS];
    pixel_t              shift_d [COLS];
    pixel_t              hold_q  [COLS];
    pixel_t              hold_d  [COLS];
    state_t              state_q, state_d;
    logic [COL_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [OE_CNT_W-1:0] oe_cnt_q, oe_cnt_d;
    logic [OE_CNT_W-1:0] oe_cycles_q, oe_cycles_d;
    logic                prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0]   prev_row_q, prev_row_d;
    logic                row_done_q, row_done_d;
    logic                frame_start_q, frame_start_d;
    logic                len_err_q, len_err_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        shift_d       = shift_q;
        hold_d        = hold_q;
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        pix_cnt_d     = pix_cnt_q;
        oe_cnt_d      = oe_cnt_q;
        oe_cycles_d   = oe_cycles_q;
        prev_valid_d  = prev_valid_q;
        prev_row_d    = prev_row_q;
        row_done_d    = 1'b0;
        frame_start_d = 1'b0;
        len_err_d     = 1'b0;
        overrun_d     = 1'b0;

        // New pixels enter at col 0, so the first pixel of a row ends up in the last column.
        if (clk_rise) begin
            for (int i = 1; i < COLS; i++) begin
                shift_d[i] = shift_q[i-1];
            end
            shift_d[0] = rgb_s;
            if (pix_cnt_q != PIX_MAX) begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
        end

        if (!oe_s && (oe_cnt_q != '1)) begin
            oe_cnt_d = oe_cnt_q + OE_CNT_W'(1);
        end

        if ((state_q == ST_DRAIN) && wr_ready) begin
            if (idx_q == COL_LAST) begin
                idx_d      = '0;
                state_d    = ST_IDLE;
                row_done_d = 1'b1;
            end else begin
                idx_d = idx_q + COL_W'(1);
            end
        end

        // Commit sees shift_d so a pixel edge in the same cycle is part of the row.
        if (lat_rise) begin
            len_err_d   = (pix_cnt_d != PIX_FULL);
            pix_cnt_d   = '0;
            oe_cycles_d = oe_cnt_q;
            oe_cnt_d    = '0;
            if (state_q == ST_IDLE) begin
                hold_d        = shift_d;
                row_d         = addr_s;
                idx_d         = '0;
                state_d       = ST_DRAIN;
                frame_start_d = (addr_s == '0) && (!prev_valid_q || (prev_row_q != '0));
                prev_valid_d  = 1'b1;
                prev_row_d    = addr_s;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q       <= '{default: '0};
            hold_q        <= '{default: '0};
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            row_q         <= '0;
            pix_cnt_q     <= '0;
            oe_cnt_q      <= '0;
            oe_cycles_q   <= '0;
            prev_valid_q  <= 1'b0;
            prev_row_q    <= '0;
            row_done_q    <= 1'b0;
            frame_start_q <= 1'b0;
            len_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            pix_cnt_q     <= pix_cnt_d;
            oe_cnt_q      <= oe_cnt_d;
            oe_cycles_q   <= oe_cycles_d;
            prev_valid_q  <= prev_valid_d;
            prev_row_q    <= prev_row_d;
            row_done_q    <= row_done_d;
            frame_start_q <= frame_start_d;
            len_err_q     <= len_err_d;
            overrun_q     <= overrun_d;
        end
    end

    pixel_t beat_px;
    assign beat_px = hold_q[idx_q];

    assign wr_valid    = (state_q == ST_DRAIN);
    assign wr_addr     = {row_q, idx_q};
    assign wr_data     = {beat_px[R0], beat_px[G0], beat_px[B0],
                          beat_px[R1], beat_px[G1], beat_px[B1]};
    assign row_done    = row_done_q;
    assign frame_start = frame_start_q;
    assign len_err     = len_err_q;
    assign overrun     = overrun_q;
    assign oe_cycles   = oe_cycles_q;

endmodule

// File: tb/tb_hub75_panel_capture.sv
// Randomized bench for hub75_panel_capture against a pixel-history reference model.
module tb_hub75_panel_capture;

    localparam int COLS = 32;
    localparam int HP   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hub_clk = 1'b0;
    logic       hub_lat = 1'b0;
    logic       hub_oe = 1'b1;
    logic [2:0] hub_addr = '0;
    logic [5:0] hub_rgb = '0;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic [7:0] wr_addr;
    logic [5:0] wr_data;
    logic       row_done, frame_start, len_err, overrun;
    logic [15:0] oe_cycles;

    always #5 clk = ~clk;

    hub75_panel_capture #(
        .COLS(32), .ADDR_W(3), .SYNC_STAGES(2), .OE_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
        .hub_addr(hub_addr), .hub_rgb(hub_rgb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .row_done(row_done), .frame_start(frame_start),
        .len_err(len_err), .overrun(overrun), .oe_cycles(oe_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: history of pixels shifted since reset, last COLS kept.
    logic [5:0]  hist[$];
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    bit prev_valid;
    int prev_row;
    int e_len = 0, e_frame = 0, e_ovr = 0, e_done = 0;
    int c_len = 0, c_frame = 0, c_ovr = 0, c_done = 0;
    int frame_row = -1;
    bit rand_ready = 0;

    task automatic model_reset();
        hist.delete();
        repeat (COLS) hist.push_back(6'd0);
        prev_valid = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) obs_q.push_back({wr_addr, wr_data});
            if (row_done) c_done++;
            if (len_err) c_len++;
            if (overrun) c_ovr++;
            if (frame_start) begin
                c_frame++;
                frame_row = int'(wr_addr[7:5]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic hub_pixel(input logic [5:0] pix, input bit with_lat);
        hub_rgb = pix;
        hub_clk = 1'b0;
        tick(HP);
        hub_clk = 1'b1;
        if (with_lat) hub_lat = 1'b1;
        tick(HP);
        hub_clk = 1'b0;
        hub_lat = 1'b0;
    endtask

    task automatic send_row(input int a, input int n, input bit ramp, input bit coincide,
                            input bit accepted);
        logic [5:0] pix;
        logic [2:0] a3;
        logic [4:0] k5;
        hub_addr = 3'(a);
        for (int i = 0; i < n; i++) begin
            pix = ramp ? 6'(i) : 6'($urandom_range(0, 63));
            hub_pixel(pix, coincide && (i == n - 1));
            hist.push_back(pix);
            if (hist.size() > COLS) void'(hist.pop_front());
        end
        if (!coincide || n == 0) begin
            hub_lat = 1'b1;
            tick(HP);
            hub_lat = 1'b0;
        end
        tick(HP);
        if (n != COLS) e_len++;
        if (accepted) begin
            a3 = 3'(a);
            for (int k = 0; k < COLS; k++) begin
                k5 = 5'(k);
                exp_q.push_back({a3, k5, hist[COLS-1-k]});
            end
            if (a == 0 && (!prev_valid || prev_row != 0)) e_frame++;
            prev_valid = 1;
            prev_row = a;
            e_done++;
        end else begin
            e_ovr++;
        end
    endtask

    task automatic drain_check(input string tag);
        int t = 0;
        while ((obs_q.size() < exp_q.size() || wr_valid) && t < 600) begin
            tick(1);
            t++;
        end
        chk({tag, " drain_done"}, 32'(t < 600), 32'd1);
        tick(3);
        chk({tag, " beats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, " len_err_cnt"}, c_len, e_len);
        chk({tag, " frame_cnt"}, c_frame, e_frame);
        chk({tag, " overrun_cnt"}, c_ovr, e_ovr);
        chk({tag, " row_done_cnt"}, c_done, e_done);
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        model_reset();
        tick(4);
        chk("rst wr_valid", wr_valid, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst flags", {row_done, frame_start, len_err, overrun}, 0);
        chk("rst oe_cycles", oe_cycles, 0);
        rst = 1'b0;
        tick(4);
        chk("idle wr_valid", wr_valid, 0);

        send_row(5, 32, 1, 0, 1);
        drain_check("ramp");

        send_row(7, 32, 0, 0, 1);
        drain_check("row7");
        send_row(0, 32, 0, 0, 1);
        drain_check("row0");
        chk("frame row", frame_row, 0);
        send_row(0, 32, 0, 1, 1);
        drain_check("row0 again coincide");

        send_row(1, 30, 0, 0, 1);
        drain_check("short30");
        send_row(6, 33, 0, 0, 1);
        drain_check("long33");

        rand_ready = 0;
        wr_ready = 1'b0;
        send_row(2, 32, 0, 0, 1);
        tick(5);
        chk("stall valid", wr_valid, 1);
        chk("stall beat", {wr_addr, wr_data}, exp_q[0]);
        send_row(3, 32, 0, 0, 0);
        chk("stall beat hold", {wr_addr, wr_data}, exp_q[0]);
        wr_ready = 1'b1;
        drain_check("overrun");
        tick(60);
        chk("dropped row beats", obs_q.size(), 0);

        tick(1);
        hub_oe = 1'b0;
        tick(100);
        hub_oe = 1'b1;
        send_row(4, 32, 0, 0, 1);
        drain_check("oe100");
        chk("oe_cycles 100", oe_cycles, 100);
        hub_oe = 1'b0;
        tick(70000);
        hub_oe = 1'b1;
        send_row(4, 32, 0, 0, 1);
        drain_check("oe70000");
        chk("oe_cycles sat", oe_cycles, 65535);

        for (int r = 0; r < 8; r++) begin
            int a, sel, n;
            a = $urandom_range(0, 7);
            sel = $urandom_range(0, 5);
            n = (sel == 0) ? 31 : (sel == 1) ? 33 : 32;
            rand_ready = 1;
            send_row(a, n, 0, bit'($urandom_range(0, 1)), 1);
            drain_check($sformatf("rand%0d", r));
        end
        rand_ready = 0;
        tick(1);
        wr_ready = 1'b1;

        send_row(4, 32, 0, 0, 1);
        t = 0;
        while (obs_q.size() < 10 && t < 200) begin
            tick(1);
            t++;
        end
        chk("reach beat10", 32'(t < 200), 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst wr_valid", wr_valid, 0);
        chk("async rst flags", {row_done, frame_start, len_err, overrun}, 0);
        tick(3);
        rst = 1'b0;
        e_done--;
        model_reset();
        tick(3);
        send_row(0, 32, 0, 0, 1);
        drain_check("after rst row0");
        chk("frame row after rst", frame_row, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
